// File: rtl/minimig_autoconfig_ctrl_if.sv
// CPU-side bus for the autoconfig window: level-held select, one-cycle ack.
interface minimig_autoconfig_ctrl_if;
  logic        sel;
  logic        rw;
  logic [5:0]  addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        ack;

  modport master (output sel, rw, addr, data_in, input data_out, ack);
  modport slave  (input sel, rw, addr, data_in, output data_out, ack);
endinterface

// File: rtl/minimig_autoconfig_ctrl.sv
// Autoconfig responder: serves descriptor nibbles for the current chain slot,
// latches OS-assigned base addresses and handles shut-up.
module minimig_autoconfig_ctrl #(
  parameter int         NUM_SLOTS = 7,
  parameter logic [6:0] Z3_MASK   = 7'b0011110,
  parameter int         NULL_SLOT = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  board_en,
  minimig_autoconfig_ctrl_if.slave bus,
  output logic [8:0]  rom_a,
  input  logic [3:0]  rom_q,
  output logic [7:0]  base_z2,
  output logic [15:0] base_z3a,
  output logic [15:0] base_z3b,
  output logic [15:0] base_z3c,
  output logic [15:0] base_eth,
  output logic [7:0]  base_snd,
  output logic [7:0]  base_ctrl,
  output logic [6:0]  configured,
  output logic [6:0]  active,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_W, RD_D, WR, RELEASE} state_t;

  state_t      state_q, state_d;
  logic        sel_q;
  logic [2:0]  slot_q, slot_d;
  logic [8:0]  rom_a_q, rom_a_d;
  logic [15:0] data_out_q, data_out_d;
  logic        ack_q, ack_d;
  logic [3:0]  pending_q, pending_d;
  logic [15:0] base_q [NUM_SLOTS];
  logic [15:0] base_d [NUM_SLOTS];
  logic [6:0]  configured_q, configured_d;
  logic [6:0]  active_q, active_d;
  logic        done_q;

  logic [6:0]  avail_s;
  logic [2:0]  cur_slot_s;
  logic        done_s;
  logic        z3_s;

  assign avail_s = board_en & ~configured_q;
  assign done_s  = (avail_s == 7'd0);
  assign z3_s    = Z3_MASK[slot_q];

  // lowest enabled, unconfigured slot; falls back to the null descriptor page
  always_comb begin
    cur_slot_s = 3'(NULL_SLOT);
    for (int n = NUM_SLOTS - 1; n >= 0; n--) begin
      cur_slot_s = avail_s[n] ? 3'(n) : cur_slot_s;
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    rom_a_d      = rom_a_q;
    data_out_d   = data_out_q;
    ack_d        = 1'b0;
    pending_d    = pending_q;
    base_d       = base_q;
    configured_d = configured_q;
    active_d     = active_q;

    case (state_q)
      IDLE: begin
        if (sel_q) begin
          slot_d = cur_slot_s;
          if (bus.rw) begin
            rom_a_d = {cur_slot_s, bus.addr};
            state_d = RD_A;
          end else begin
            state_d = WR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_A: state_d = RD_W;
      RD_W: state_d = RD_D;
      RD_D: begin
        data_out_d = {rom_q, 12'hFFF};
        ack_d      = 1'b1;
        state_d    = RELEASE;
      end
      WR: begin
        ack_d   = 1'b1;
        state_d = RELEASE;
        // slot_q equals the null page once the chain is exhausted: nothing to decode
        if (slot_q < 3'(NUM_SLOTS)) begin
          case (bus.addr)
            6'h25: pending_d = z3_s ? pending_q : bus.data_in[15:12];
            6'h24: begin
              if (!z3_s) begin
                base_d[slot_q]       = {8'h00, bus.data_in[15:12], pending_q};
                configured_d[slot_q] = 1'b1;
                active_d[slot_q]     = 1'b1;
                pending_d            = 4'h0;
              end else begin
                pending_d = pending_q;
              end
            end
            6'h22: begin
              if (z3_s) begin
                base_d[slot_q]       = bus.data_in;
                configured_d[slot_q] = 1'b1;
                active_d[slot_q]     = 1'b1;
                pending_d            = 4'h0;
              end else begin
                pending_d = pending_q;
              end
            end
            6'h26: begin
              configured_d[slot_q] = 1'b1;
              pending_d            = 4'h0;
            end
            default: pending_d = pending_q;
          endcase
        end else begin
          pending_d = pending_q;
        end
      end
      RELEASE: state_d = sel_q ? RELEASE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      slot_q       <= 3'd0;
      rom_a_q      <= 9'd0;
      data_out_q   <= 16'hFFFF;
      ack_q        <= 1'b0;
      pending_q    <= 4'h0;
      configured_q <= 7'd0;
      active_q     <= 7'd0;
      done_q       <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        base_q[i] <= 16'h0000;
      end
    end else begin
      state_q      <= state_d;
      sel_q        <= bus.sel;
      slot_q       <= slot_d;
      rom_a_q      <= rom_a_d;
      data_out_q   <= data_out_d;
      ack_q        <= ack_d;
      pending_q    <= pending_d;
      configured_q <= configured_d;
      active_q     <= active_d;
      done_q       <= done_s;
      base_q       <= base_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.ack      = ack_q;
  assign rom_a        = rom_a_q;
  assign configured   = configured_q;
  assign active       = active_q;
  assign done         = done_q;
  assign base_z2      = base_q[0][7:0];
  assign base_z3a     = base_q[1];
  assign base_z3b     = base_q[2];
  assign base_z3c     = base_q[3];
  assign base_eth     = base_q[4];
  assign base_snd     = base_q[5][7:0];
  assign base_ctrl    = base_q[6][7:0];

endmodule

// File: tb/tb_minimig_autoconfig_ctrl.sv
// Self-checking bench: table of accesses plus reset, sel-hold and chain-exhausted sequences.
module tb_minimig_autoconfig_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  board_en;
  logic [8:0]  rom_a;
  logic [3:0]  rom_q;
  logic [3:0]  rom_s1;
  logic [7:0]  base_z2, base_snd, base_ctrl;
  logic [15:0] base_z3a, base_z3b, base_z3c, base_eth;
  logic [6:0]  configured, active;
  logic        done;

  minimig_autoconfig_ctrl_if bus ();

  minimig_autoconfig_ctrl dut (
    .clk(clk), .reset(reset), .board_en(board_en), .bus(bus),
    .rom_a(rom_a), .rom_q(rom_q),
    .base_z2(base_z2), .base_z3a(base_z3a), .base_z3b(base_z3b), .base_z3c(base_z3c),
    .base_eth(base_eth), .base_snd(base_snd), .base_ctrl(base_ctrl),
    .configured(configured), .active(active), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_val(input logic [8:0] a);
    if (a[8:6] == 3'd7) return 4'hF;
    return 4'hE ^ a[3:0] ^ {1'b0, a[8:6]};
  endfunction

  // descriptor store with two-edge read latency
  always @(posedge clk) begin
    rom_s1 <= rom_val(rom_a);
    rom_q  <= rom_s1;
  end

  typedef struct { bit rd; logic [15:0] data; } exp_t;
  typedef struct {
    bit rd; logic [5:0] addr; logic [15:0] wdata;
    logic [8:0] rom_a; logic [6:0] cfg; logic [6:0] act;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[10];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   ack_count = 0;

  task automatic chk(input string name, input logic [15:0] act_v, input logic [15:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // scoreboard: every ack consumes one expectation
  always @(negedge clk) begin
    if (bus.ack) begin
      exp_t e;
      ack_count++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=1 expected no access at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (e.rd) chk("rd_data", bus.data_out, e.data);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic access(input bit rd, input logic [5:0] a, input logic [15:0] d,
                        input logic [8:0] exp_rom_a);
    exp_t e;
    int   lat;
    bit   got;
    e.rd   = rd;
    e.data = {rom_val(exp_rom_a), 12'hFFF};
    exp_q.push_back(e);
    bus.sel = 1'b1; bus.rw = rd; bus.addr = a; bus.data_in = d;
    lat = 0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      lat++;
      got = bus.ack;
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL ack_timeout: got no ack expected ack within 20 cycles");
      void'(exp_q.pop_front());
    end else begin
      chk(rd ? "rd_ack_lat" : "wr_ack_lat", 16'(lat), rd ? 16'd5 : 16'd3);
    end
    bus.sel = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", 16'(bus.ack), 16'd0);
    idle(3);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_snap;
    tbl[0] = '{1'b1, 6'h00, 16'h0000, 9'h000, 7'h00, 7'h00};
    tbl[1] = '{1'b0, 6'h25, 16'h0000, 9'h000, 7'h00, 7'h00};
    tbl[2] = '{1'b0, 6'h24, 16'h2000, 9'h000, 7'h01, 7'h01};
    tbl[3] = '{1'b1, 6'h00, 16'h0000, 9'h040, 7'h01, 7'h01};
    tbl[4] = '{1'b0, 6'h22, 16'h4000, 9'h000, 7'h03, 7'h03};
    tbl[5] = '{1'b1, 6'h00, 16'h0000, 9'h080, 7'h03, 7'h03};
    tbl[6] = '{1'b0, 6'h26, 16'h0000, 9'h000, 7'h07, 7'h03};
    tbl[7] = '{1'b1, 6'h00, 16'h0000, 9'h0C0, 7'h07, 7'h03};
    tbl[8] = '{1'b0, 6'h24, 16'h1234, 9'h000, 7'h07, 7'h03};
    tbl[9] = '{1'b1, 6'h05, 16'h0000, 9'h0C5, 7'h07, 7'h03};

    bus.sel = 1'b0; bus.rw = 1'b1; bus.addr = 6'h00; bus.data_in = 16'h0000;
    board_en = 7'h7F;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);
    chk("rst_ack", 16'(bus.ack), 16'd0);
    chk("rst_data_out", bus.data_out, 16'hFFFF);
    chk("rst_rom_a", 16'(rom_a), 16'h0000);
    chk("rst_configured", 16'(configured), 16'h0000);
    chk("rst_active", 16'(active), 16'h0000);
    chk("rst_done", 16'(done), 16'd0);

    foreach (tbl[i]) begin
      access(tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].rom_a);
      if (tbl[i].rd) chk("tbl_rom_a", 16'(rom_a), 16'(tbl[i].rom_a));
      chk("tbl_configured", 16'(configured), 16'(tbl[i].cfg));
      chk("tbl_active", 16'(active), 16'(tbl[i].act));
    end
    chk("base_z2", 16'(base_z2), 16'h0020);
    chk("base_z3a", base_z3a, 16'h4000);
    chk("base_z3b", base_z3b, 16'h0000);
    chk("base_z3c", base_z3c, 16'h0000);
    chk("done_mid_chain", 16'(done), 16'd0);

    // sel held after ack must not produce a second ack
    ack_snap = ack_count;
    begin
      exp_t e;
      e.rd = 1'b1; e.data = {rom_val(9'h0C1), 12'hFFF};
      exp_q.push_back(e);
    end
    bus.sel = 1'b1; bus.rw = 1'b1; bus.addr = 6'h01;
    idle(15);
    chk("held_sel_acks", 16'(ack_count - ack_snap), 16'd1);
    bus.sel = 1'b0;
    idle(4);

    // reset while in RD_W aborts the access with no ack
    ack_snap = ack_count;
    bus.sel = 1'b1; bus.rw = 1'b1; bus.addr = 6'h02;
    idle(3);
    reset = 1'b1; bus.sel = 1'b0;
    idle(1);
    reset = 1'b0;
    idle(6);
    chk("abort_no_ack", 16'(ack_count - ack_snap), 16'd0);
    chk("abort_data_out", bus.data_out, 16'hFFFF);
    chk("abort_rom_a", 16'(rom_a), 16'h0000);
    chk("abort_configured", 16'(configured), 16'h0000);
    chk("abort_active", 16'(active), 16'h0000);
    chk("abort_base_z2", 16'(base_z2), 16'h0000);
    chk("abort_base_z3a", base_z3a, 16'h0000);

    // disabling the current slot moves the chain on
    board_en = 7'h7E;
    access(1'b1, 6'h00, 16'h0000, 9'h040);
    chk("skip_rom_a", 16'(rom_a), 16'h0040);

    // sparse chain: slot 0 with nonzero pending nibble, then shut up slot 6
    board_en = 7'b1000001;
    access(1'b0, 6'h25, 16'hA000, 9'h000);
    access(1'b0, 6'h24, 16'h3000, 9'h000);
    chk("sparse_base_z2", 16'(base_z2), 16'h003A);
    chk("sparse_configured", 16'(configured), 16'h0001);
    access(1'b1, 6'h00, 16'h0000, 9'h180);
    chk("slot6_rom_a", 16'(rom_a), 16'h0180);
    access(1'b0, 6'h26, 16'h0000, 9'h000);
    chk("shutup_configured", 16'(configured), 16'h0041);
    chk("shutup_active", 16'(active), 16'h0001);
    chk("done_set", 16'(done), 16'd1);
    access(1'b1, 6'h00, 16'h0000, 9'h1C0);
    chk("null_rom_a", 16'(rom_a), 16'h01C0);
    chk("null_data", bus.data_out, 16'hFFFF);
    access(1'b0, 6'h24, 16'h5000, 9'h000);
    chk("done_wr_configured", 16'(configured), 16'h0041);
    chk("done_wr_active", 16'(active), 16'h0001);
    chk("done_wr_base_z2", 16'(base_z2), 16'h003A);
    chk("done_wr_base_ctrl", 16'(base_ctrl), 16'h0000);
    chk("base_snd", 16'(base_snd), 16'h0000);
    chk("base_eth", base_eth, 16'h0000);
    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/minimig_autoconfig_ctrl.md
Name: minimig_autoconfig_ctrl

Overview:
Autoconfig responder and sequencer for the Minimig expansion chain. It decodes CPU accesses to the $E8xxxx autoconfig window and reads the per-board descriptor nibbles from the 512x4 autoconfig descriptor store. It latches the base addresses written by the OS, handles shut-up, and advances through the board chain. The consumers are the Fast RAM, Ethernet, sound and control-board address decoders.

Parameters:
NUM_SLOTS, 7, number of chain slots (slot n descriptors at store index n*64)
Z3_MASK, 7'b0011110, bit n set = slot n is Zorro III, clear = Zorro II
NULL_SLOT, 7, descriptor page read when the chain is exhausted

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
board_en  in  7  slot present/enabled; slot n maps to bit n
sel  in  1  CPU access to autoconfig window; level, held until ack
rw  in  1  1=read, 0=write
addr  in  6  word offset within window (CPU A6:A1)
data_in  in  16  CPU write data
data_out  out  16  read data, valid while ack=1
ack  out  1  one-cycle access completion pulse
rom_a  out  9  descriptor store read address (registered)
rom_q  in  4  descriptor store data; valid 2 edges after rom_a changes
base_z2  out  8  slot 0 base, A23:A16
base_z3a  out  16  slot 1 base, A31:A16
base_z3b  out  16  slot 2 base, A31:A16
base_z3c  out  16  slot 3 base, A31:A16
base_eth  out  16  slot 4 base, A31:A16
base_snd  out  8  slot 5 base, A23:A16
base_ctrl  out  8  slot 6 base, A23:A16
configured  out  7  slot finished (base assigned or shut up)
active  out  7  slot has an assigned base
done  out  1  no enabled unconfigured slot remains

Behaviour:
- Reset: all base registers 0, configured=0, active=0, ack=0, data_out=16'hFFFF, rom_a=0, pending nibble=0, FSM=IDLE. Reset mid-access aborts it with no ack.
- Current slot: the lowest n with board_en[n]=1 and configured[n]=0. If no such n, current slot = NULL_SLOT and done=1. Current slot is sampled only in IDLE and held for the whole access.
- FSM states: IDLE, RD_A, RD_W, RD_D, WR, RELEASE.
- IDLE, sel=1, rw=1: rom_a <= {slot[2:0], addr}; go to RD_A. Then RD_A -> RD_W -> RD_D.
- RD_D: data_out <= {rom_q, 12'hFFF}; ack <= 1; go to RELEASE.
- Read timing: sel sampled at edge E0 gives ack high in the cycle following edge E0+4.
- Nibbles are passed through unmodified; inversion is encoded in the store.
- IDLE, sel=1, rw=0: go to WR. WR: decode the write, ack <= 1, go to RELEASE. Write ack is high in the cycle following edge E0+2.
- Write decode, Zorro II slot:
  - offset 0x4A (addr=6'h25): pending <= data_in[15:12].
  - offset 0x48 (addr=6'h24): base <= {data_in[15:12], pending}; configured[n] <= 1; active[n] <= 1.
- Write decode, Zorro III slot:
  - offset 0x44 (addr=6'h22): base <= data_in[15:0]; configured[n] <= 1; active[n] <= 1.
  - A 0x48 write to a Z3 slot is ignored.
- Any slot, offset 0x4C (addr=6'h26): shut-up. configured[n] <= 1; active[n] and base unchanged.
- Writes to other offsets, or while done=1: acked, no state change.
- RELEASE: ack <= 0; remain until sel=0, then IDLE. A new access requires sel to drop first, so there is never a double ack.
- ack is high for exactly 1 cycle per access.
- Once configured, a slot's base and flags hold until reset. board_en changes never clear them.
- Deasserting board_en for the current slot between accesses makes the next slot current.
- pending is cleared on every chain advance.

Test Plan:
- Reset, board_en=7'h7F; read addr 0 -> rom_a=9'h000, ack 4 cycles after sel, data_out={rom_q,12'hFFF}; store value 4'b1110 gives 16'hEFFF.
- Z2 configure: write 0x4A data 16'h0000, then 0x48 data 16'h2000 -> base_z2=8'h20, configured=7'h01; next read addr 0 gives rom_a=9'h040.
- Z3 configure: with slot 1 current, write 0x44 data 16'h4000 -> base_z3a=16'h4000, active[1]=1; next read gives rom_a=9'h080.
- Shut-up: with slot 2 current, write 0x4C -> configured[2]=1, active[2]=0, base_z3b=0; chain advances to slot 3 (rom_a=9'h0C0).
- board_en=7'b1000001: configure slot 0, then shut up slot 6 -> done=1; a read of addr 0 gives rom_a=9'h1C0 and data_out=16'hFFFF; a write to 0x48 is acked with no change.
- Assert reset while in RD_W -> no ack, all outputs at reset values. Hold sel high after ack -> no second ack until sel drops.
